spi_pwm_peripheral: RTL and testbench
=====================================

Name: spi_pwm_peripheral

Overview:
- Top-level user block with a write-only SPI (mode 0) target that loads a small register file controlling 16 outputs (uo_out and uio_out).
- Each output can be held at 0, held at 1, or driven by a shared 8-bit PWM waveform.
- The block uses the standard tile pin interface.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on SCLK/COPI/nCS (minimum 2).
- PWM_DIV, 1, system clocks per PWM counter step (1 = step every clk).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ena  in  1  tile enable; ignored (design always active).
- ui_in  in  8  [0]=SCLK, [1]=COPI, [2]=nCS (active-low); [7:3] unused.
- uio_in  in  8  unused.
- uo_out  out  8  output channels 0..7.
- uio_out  out  8  output channels 8..15.
- uio_oe  out  8  constant 8'hFF.

Behaviour:
- Reset: every register is 0, the SPI shift register and bit counter are cleared, and the PWM counter is 0. As a result uo_out=0, uio_out=0, uio_oe=FF. Reset mid-transaction discards the partial frame.
- Synchronizers: SCLK, COPI and nCS each pass through SYNC_STAGES flip-flops. An SCLK rising edge is detected when the previous synchronized value is 0 and the current is 1.
- SPI framing: MSB first. On each SCLK rising edge while synchronized nCS=0, shift COPI into a 16-bit register and increment the bit counter, which saturates at 17.
- Frame format: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- Commit condition: on the synchronized nCS rising edge, the frame commits only if the bit counter is exactly 16, bit15 = 1 and the address is valid. Committed data is written on the following clk. Any other frame is silently dropped. The bit counter clears on every nCS rising edge.
- Registers:
  - 0x00 en_uo: output enable for uo_out.
  - 0x01 en_uio: output enable for uio_out.
  - 0x02 pwm_uo: PWM select for uo_out.
  - 0x03 pwm_uio: PWM select for uio_out.
  - 0x04 duty: PWM duty value.
  - Addresses 0x05..0x7F are ignored (see Optional Feature for 0x05).
- PWM timing: an 8-bit counter increments every PWM_DIV clocks and wraps 255→0 (period 256·PWM_DIV clocks).
- PWM value: pwm = (cnt < duty), except duty = FF forces pwm = 1. So duty 0 gives constant 0, and duty 0x80 gives 50%.
- Per output bit i: out = en[i] ? (pwm_sel[i] ? pwm : 1) : 0. Outputs are registered (one clk after the internal value changes).
- A duty write takes effect immediately without waiting for a period boundary. Glitches at the write point are acceptable.
- Read frames (bit15 = 0) have no effect. There is no CIPO output.

Optional Feature:
- Macro PWM_POLARITY_EN.
- When defined: register 0x05 pol_uo and 0x06 pol_uio become writable (reset 0). For each PWM-selected bit with pol[i] = 1, the PWM level is inverted. Enabled non-PWM bits and disabled bits are unaffected.
- When undefined: addresses 0x05/0x06 are ignored like any other invalid address, and there is no polarity inversion.

Decomposition:
- Package spi_pwm_pkg holds:
  - address constants ADDR_EN_UO..ADDR_DUTY (and ADDR_POL_UO/ADDR_POL_UIO);
  - FRAME_BITS = 16;
  - a register-file struct typedef.
- One natural sub-module: spi_pwm_spi_rx (synchronizers, shift register, bit counter). It emits a one-cycle wr_stb with addr[6:0]/data[7:0].
- Register file, PWM counter and output muxing stay in the top.

Test Plan:
- Reset check: after reset → uo_out = 00, uio_out = 00, uio_oe = FF.
- Static enable: write 0x00←0xF0 then 0x01←0x0F → uo_out = F0, uio_out = 0F; no PWM activity.
- 50% duty: write 0x00←0x01, 0x02←0x01, 0x04←0x80, PWM_DIV = 1 → uo_out[0] is high 128 of every 256 clocks, period 256 clocks. Then duty←0x00 → constant 0; duty←0xFF → constant 1.
- Frame rejection: a 15-bit frame, a 17-bit frame, a read frame (bit15 = 0) to 0x00 with data 0xFF, and a write to address 0x7F → all registers unchanged, outputs unchanged.
- Mid-frame reset: assert rst after 8 SCLK edges, then send a valid write 0x01←0xAA → uio_out = AA, with no corruption from the partial frame.
- Polarity (PWM_POLARITY_EN only): duty 0x40 on channel 0 with pol_uo←0x01 → uo_out[0] is high 192 of 256 clocks.

Source files
------------

// File: rtl/spi_pwm_pkg.sv
// Shared constants and types for the SPI-controlled PWM output block.
// Optional macro PWM_POLARITY_EN enables the polarity registers at 0x05/0x06.
package spi_pwm_pkg;

    localparam int FRAME_BITS = 16;
    localparam int BIT_CNT_W  = 5;

    localparam logic [6:0] ADDR_EN_UO   = 7'h00;
    localparam logic [6:0] ADDR_EN_UIO  = 7'h01;
    localparam logic [6:0] ADDR_PWM_UO  = 7'h02;
    localparam logic [6:0] ADDR_PWM_UIO = 7'h03;
    localparam logic [6:0] ADDR_DUTY    = 7'h04;
    localparam logic [6:0] ADDR_POL_UO  = 7'h05;
    localparam logic [6:0] ADDR_POL_UIO = 7'h06;

    typedef struct packed {
        logic [7:0] en_uo;
        logic [7:0] en_uio;
        logic [7:0] pwm_uo;
        logic [7:0] pwm_uio;
        logic [7:0] duty;
        logic [7:0] pol_uo;
        logic [7:0] pol_uio;
    } regfile_t;

    // Per bit: disabled -> 0, enabled static -> 1, enabled PWM -> pwm ^ pol.
    function automatic logic [7:0] drive_bits(input logic [7:0] en,
                                              input logic [7:0] sel,
                                              input logic [7:0] pol,
                                              input logic       pwm);
        logic [7:0] lvl;
        lvl = {8{pwm}} ^ pol;
        return en & ((sel & lvl) | ~sel);
    endfunction

endpackage

// File: rtl/spi_pwm_spi_rx.sv
// Write-only SPI mode-0 target: input synchronizers, MSB-first shifter and
// bit counter; emits a one-cycle write strobe for each well-formed write frame.
module spi_pwm_spi_rx
    import spi_pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       copi_i,
    input  logic       ncs_i,
    output logic       wr_stb,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data
);

    localparam logic [BIT_CNT_W-1:0] CNT_FULL = BIT_CNT_W'(FRAME_BITS);
    localparam logic [BIT_CNT_W-1:0] CNT_SAT  = BIT_CNT_W'(FRAME_BITS + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ncs_prev_q,  ncs_prev_d;
    logic [FRAME_BITS-1:0]  shift_q,     shift_d;
    logic [BIT_CNT_W-1:0]   cnt_q,       cnt_d;
    logic                   stb_q,       stb_d;
    logic [6:0]             addr_q,      addr_d;
    logic [7:0]             data_q,      data_d;

    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign ncs_rise  = ~ncs_prev_q & ncs_s;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi_i};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs_i};
        sclk_prev_d = sclk_s;
        ncs_prev_d  = ncs_s;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        stb_d       = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;

        if (ncs_rise) begin
            cnt_d = '0;
            if ((cnt_q == CNT_FULL) && shift_q[FRAME_BITS-1]) begin
                stb_d  = 1'b1;
                addr_d = shift_q[14:8];
                data_d = shift_q[7:0];
            end
        end else if (sclk_rise && !ncs_s) begin
            shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // nCS idles high, so its synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            shift_q     <= '0;
            cnt_q       <= '0;
            stb_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ncs_prev_q  <= ncs_prev_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            stb_q       <= stb_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign wr_stb  = stb_q;
    assign wr_addr = addr_q;
    assign wr_data = data_q;

endmodule

// File: rtl/spi_pwm_peripheral.sv
// SPI-programmed 16-channel output block: each channel held low, high or PWM.
// Optional macro PWM_POLARITY_EN adds writable PWM polarity registers 0x05/0x06.
module spi_pwm_peripheral
    import spi_pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PWM_DIV     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

`ifdef PWM_POLARITY_EN
    localparam bit POL_EN = 1'b1;
`else
    localparam bit POL_EN = 1'b0;
`endif

    localparam int              DIV_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PWM_DIV - 1);

    logic       wr_stb;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    regfile_t   regs_q,    regs_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0] uo_q,      uo_d;
    logic [7:0] uio_q,     uio_d;
    logic       pwm;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

    spi_pwm_spi_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_spi_rx (
        .clk    (clk),
        .rst    (rst),
        .sclk_i (ui_in[0]),
        .copi_i (ui_in[1]),
        .ncs_i  (ui_in[2]),
        .wr_stb (wr_stb),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    // Polarity registers exist in both builds but are only writable with the
    // feature on; left at reset 0 they leave the PWM level untouched.
    always_comb begin
        regs_d = regs_q;
        if (wr_stb) begin
            case (wr_addr)
                ADDR_EN_UO:   regs_d.en_uo   = wr_data;
                ADDR_EN_UIO:  regs_d.en_uio  = wr_data;
                ADDR_PWM_UO:  regs_d.pwm_uo  = wr_data;
                ADDR_PWM_UIO: regs_d.pwm_uio = wr_data;
                ADDR_DUTY:    regs_d.duty    = wr_data;
                ADDR_POL_UO:  if (POL_EN) regs_d.pol_uo  = wr_data;
                ADDR_POL_UIO: if (POL_EN) regs_d.pol_uio = wr_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        div_d     = div_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q;
        if (div_q == DIV_LAST) begin
            div_d     = '0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end
    end

    assign pwm = (regs_q.duty == 8'hFF) || (pwm_cnt_q < regs_q.duty);

    always_comb begin
        uo_d  = drive_bits(regs_q.en_uo,  regs_q.pwm_uo,  regs_q.pol_uo,  pwm);
        uio_d = drive_bits(regs_q.en_uio, regs_q.pwm_uio, regs_q.pol_uio, pwm);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q    <= '0;
            div_q     <= '0;
            pwm_cnt_q <= '0;
            uo_q      <= '0;
            uio_q     <= '0;
        end else begin
            regs_q    <= regs_d;
            div_q     <= div_d;
            pwm_cnt_q <= pwm_cnt_d;
            uo_q      <= uo_d;
            uio_q     <= uio_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = uio_q;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_spi_pwm_peripheral.sv
// Self-checking bench for spi_pwm_peripheral: table vectors, directed PWM and
// reset sequences, and random frames scored against per-channel duty counts.
module tb_spi_pwm_peripheral;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic [7:0] ui_in;
    logic [7:0] uio_in = 8'h5A;
    logic [7:0] uo_out, uio_out, uio_oe;

    assign ui_in = {5'b00000, ncs, copi, sclk};

    always #5 clk = ~clk;

    spi_pwm_peripheral #(
        .SYNC_STAGES(2),
        .PWM_DIV    (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: register contents by address; outputs derived as duty counts.
    logic [7:0] m_reg [0:6];
`ifdef PWM_POLARITY_EN
    localparam int N_REGS = 7;
`else
    localparam int N_REGS = 5;
`endif

    typedef struct {
        logic [16:0] frame;
        int          nbits;
        logic [7:0]  exp_uo;
        logic [7:0]  exp_uio;
        string       name;
    } vec_t;

    vec_t vec [0:9];

    function automatic logic [16:0] wr(input logic [6:0] a, input logic [7:0] d);
        return {1'b0, 1'b1, a, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_reg[i] = 8'h00;
    endtask

    task automatic model_apply(input logic [16:0] f, input int n);
        int a;
        a = int'(f[14:8]);
        if (n == 16 && f[15] && a < N_REGS) m_reg[a] = f[7:0];
    endtask

    function automatic int exp_cnt(input int ch);
        int b, base;
        logic [7:0] en, sel, pol;
        b   = ch % 8;
        en  = (ch < 8) ? m_reg[0] : m_reg[1];
        sel = (ch < 8) ? m_reg[2] : m_reg[3];
        pol = (ch < 8) ? m_reg[5] : m_reg[6];
        if (!en[b]) return 0;
        if (!sel[b]) return 256;
        base = (m_reg[4] == 8'hFF) ? 256 : int'(m_reg[4]);
        return pol[b] ? 256 - base : base;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        tick(4);
        rst = 1'b0;
        model_reset();
        tick(4);
    endtask

    task automatic sclk_bit(input logic b);
        copi = b;
        tick(4);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [16:0] f, input int n);
        ncs = 1'b0;
        tick(4);
        for (int i = n - 1; i >= 0; i--) sclk_bit(f[i]);
        tick(4);
        ncs = 1'b1;
        tick(12);
        model_apply(f, n);
    endtask

    // High-time of every channel over exactly one 256-clock PWM period.
    task automatic check_window(input string name);
        int cnt [16];
        int bad_ch;
        for (int c = 0; c < 16; c++) cnt[c] = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            for (int c = 0; c < 8; c++) begin
                cnt[c]     += int'(uo_out[c]);
                cnt[c + 8] += int'(uio_out[c]);
            end
        end
        bad_ch = -1;
        for (int c = 0; c < 16; c++)
            if (bad_ch < 0 && cnt[c] != exp_cnt(c)) bad_ch = c;
        vectors++;
        if (bad_ch >= 0) begin
            miscompares++;
            $display("FAIL %s: channel %0d high %0d of 256 clocks, expected %0d",
                     name, bad_ch, cnt[bad_ch], exp_cnt(bad_ch));
        end
    endtask

    task automatic count_uo0(input int n, output int highs, output int rises);
        logic prev;
        highs = 0; rises = 0;
        @(posedge clk); #1;
        prev = uo_out[0];
        highs += int'(prev);
        for (int k = 1; k < n; k++) begin
            @(posedge clk); #1;
            highs += int'(uo_out[0]);
            if (!prev && uo_out[0]) rises++;
            prev = uo_out[0];
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, r;
        logic [6:0] a;
        logic [16:0] f;
        int n;

        vec[0] = '{wr(7'h00, 8'hF0),  16, 8'hF0, 8'h00, "en_uo_write"};
        vec[1] = '{wr(7'h01, 8'h0F),  16, 8'hF0, 8'h0F, "en_uio_write"};
        vec[2] = '{17'h000AA,         15, 8'hF0, 8'h0F, "short_frame"};
        vec[3] = '{{1'b1, 16'h80FF},  17, 8'hF0, 8'h0F, "long_frame"};
        vec[4] = '{17'h000FF,         16, 8'hF0, 8'h0F, "read_frame"};
        vec[5] = '{wr(7'h7F, 8'hFF),  16, 8'hF0, 8'h0F, "bad_addr_7f"};
        vec[6] = '{wr(7'h05, 8'hFF),  16, 8'hF0, 8'h0F, "addr_05_static"};
        vec[7] = '{wr(7'h06, 8'hFF),  16, 8'hF0, 8'h0F, "addr_06_static"};
        vec[8] = '{wr(7'h00, 8'h3C),  16, 8'h3C, 8'h0F, "en_uo_rewrite"};
        vec[9] = '{wr(7'h01, 8'hA5),  16, 8'h3C, 8'hA5, "en_uio_rewrite"};

        do_reset();
        check8("reset_uo_out",  uo_out,  8'h00);
        check8("reset_uio_out", uio_out, 8'h00);
        check8("reset_uio_oe",  uio_oe,  8'hFF);

        for (int i = 0; i < 10; i++) begin
            send_frame(vec[i].frame, vec[i].nbits);
            check8({vec[i].name, "_uo"},  uo_out,  vec[i].exp_uo);
            check8({vec[i].name, "_uio"}, uio_out, vec[i].exp_uio);
        end
        check_window("static_no_pwm");

        // 50% duty on channel 0, then the two duty extremes.
        do_reset();
        send_frame(wr(7'h00, 8'h01), 16);
        send_frame(wr(7'h02, 8'h01), 16);
        send_frame(wr(7'h04, 8'h80), 16);
        count_uo0(513, h, r);
        check_int("duty80_rises_in_512", r, 2);
        count_uo0(256, h, r);
        check_int("duty80_high_count", h, 128);
        check_window("duty80_window");
        send_frame(wr(7'h04, 8'h00), 16);
        count_uo0(256, h, r);
        check_int("duty00_high_count", h, 0);
        send_frame(wr(7'h04, 8'hFF), 16);
        count_uo0(256, h, r);
        check_int("dutyFF_high_count", h, 256);
        send_frame(wr(7'h04, 8'h01), 16);
        count_uo0(256, h, r);
        check_int("duty01_high_count", h, 1);

        // Reset in the middle of a frame must leave no trace of it.
        do_reset();
        send_frame(wr(7'h01, 8'h77), 16);
        check8("pre_midreset_uio", uio_out, 8'h77);
        ncs = 1'b0;
        tick(4);
        for (int i = 7; i >= 0; i--) sclk_bit(i[0] | (i == 7));
        tick(2);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(6);
        ncs = 1'b1;
        tick(12);
        check8("midreset_uio_cleared", uio_out, 8'h00);
        send_frame(wr(7'h01, 8'hAA), 16);
        check8("midreset_uio_AA", uio_out, 8'hAA);
        check8("midreset_uo_00",  uo_out,  8'h00);

`ifdef PWM_POLARITY_EN
        do_reset();
        send_frame(wr(7'h00, 8'h01), 16);
        send_frame(wr(7'h02, 8'h01), 16);
        send_frame(wr(7'h04, 8'h40), 16);
        send_frame(wr(7'h05, 8'h01), 16);
        count_uo0(256, h, r);
        check_int("pol_duty40_high_count", h, 192);
        check_window("pol_window");
`endif

        // Random frames scored against the register-level model.
        do_reset();
        for (int t = 0; t < 24; t++) begin
            a = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
            f = {1'($urandom_range(0, 1)), ($urandom_range(0, 6) != 0), a, 8'($urandom)};
            case ($urandom_range(0, 9))
                0:       n = 15;
                1:       n = 17;
                default: n = 16;
            endcase
            send_frame(f, n);
            if (t % 4 == 3) check_window("random_window");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
